// File: rtl/vec_lane_pkg.sv
// -----------------------------------------------------------------------------
// vec_lane_pkg
//   Shared definitions for the multi-lane vector add/subtract engine:
//   op encodings, signed saturation bounds and the lane-slice helper.
//   Bounds are returned MAX_DW wide; callers slice to their DATA_WIDTH
//   (DATA_WIDTH must not exceed MAX_DW).
// -----------------------------------------------------------------------------
package vec_lane_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int MAX_DW = 64;

    // Largest signed value of a dw-bit two's complement number: 0111..1
    function automatic logic [MAX_DW-1:0] sat_max(input int dw);
        return (MAX_DW'(1) << (dw - 1)) - MAX_DW'(1);
    endfunction

    // Smallest signed value of a dw-bit two's complement number: 1000..0
    function automatic logic [MAX_DW-1:0] sat_min(input int dw);
        return MAX_DW'(1) << (dw - 1);
    endfunction

    // LSB position of lane 'lane' inside a flat lane-packed bus
    function automatic int lane_lsb(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/vec_pipe_stage.sv
// -----------------------------------------------------------------------------
// vec_pipe_stage
//   One valid/ready register slice. Accepts a new word whenever it is empty
//   or its downstream consumer takes the current word, so bubbles collapse
//   and a chain of these sustains one word per cycle.
//   Ports:
//     clk, rst_n            clock, async active-low reset
//     in_valid/in_ready     upstream handshake
//     in_data [WIDTH]       upstream payload
//     out_valid/out_ready   downstream handshake
//     out_data [WIDTH]      registered payload (0 after reset)
// -----------------------------------------------------------------------------
module vec_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             vld;
    logic [WIDTH-1:0] dat;

    // Ready depends only on our own state and downstream ready, never on
    // in_valid, so upstream joins stay loop-free.
    assign in_ready  = !vld || out_ready;
    assign out_valid = vld;
    assign out_data  = dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            dat <= '0;
        end else if (in_ready) begin
            vld <= in_valid;
            if (in_valid) dat <= in_data;
        end
    end

endmodule

// File: rtl/vec_lane_addsub.sv
// -----------------------------------------------------------------------------
// vec_lane_addsub
//   Element-wise x +/- y over PARALLELISM two's complement lanes, with
//   optional saturation, followed by a LATENCY-deep stall-able pipeline.
//   Ports:
//     clk, rst_n                       clock, async active-low reset
//     in_x_data/in_x_valid/x_ready/x_end   x stream (lane i at [i*DW +: DW])
//     in_y_data/in_y_valid/y_ready/y_end   y stream, same packing
//     op_sub                           0 add, 1 subtract; latched per packet
//     out_data/out_valid/out_ready/out_end result stream
//     ovf_lanes                        per-lane overflow, aligned with out_data
//     err_len/err_clr                  sticky x_end != y_end flag and its clear
//     pkt_len/pkt_done                 beats in last packet, update pulse
// -----------------------------------------------------------------------------
module vec_lane_addsub
    import vec_lane_pkg::*;
#(
    parameter int PARALLELISM = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int LATENCY     = 2,
    parameter int SATURATE    = 1,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [PARALLELISM*DATA_WIDTH-1:0] in_x_data,
    input  logic                              in_x_valid,
    output logic                              x_ready,
    input  logic                              x_end,
    input  logic [PARALLELISM*DATA_WIDTH-1:0] in_y_data,
    input  logic                              in_y_valid,
    output logic                              y_ready,
    input  logic                              y_end,
    input  logic                              op_sub,
    output logic [PARALLELISM*DATA_WIDTH-1:0] out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_end,
    output logic [PARALLELISM-1:0]            ovf_lanes,
    output logic                              err_len,
    input  logic                              err_clr,
    output logic [LEN_WIDTH-1:0]              pkt_len,
    output logic                              pkt_done
);

    localparam logic [MAX_DW-1:0]     SMAX_W = sat_max(DATA_WIDTH);
    localparam logic [MAX_DW-1:0]     SMIN_W = sat_min(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] SMAX   = SMAX_W[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] SMIN   = SMIN_W[DATA_WIDTH-1:0];

    typedef struct packed {
        logic [PARALLELISM-1:0][DATA_WIDTH-1:0] data;
        logic                                   last;
        logic [PARALLELISM-1:0]                 ovf;
    } beat_t;

    localparam int BW = $bits(beat_t);

    logic                                   adv;
    logic                                   fire;
    logic                                   term;
    logic                                   pkt_start;
    logic                                   op_q;
    logic                                   op_eff;
    logic [LEN_WIDTH-1:0]                   beat_cnt;
    logic [LEN_WIDTH-1:0]                   cnt_inc;
    logic [PARALLELISM-1:0][DATA_WIDTH-1:0] x_lane;
    logic [PARALLELISM-1:0][DATA_WIDTH-1:0] y_lane;
    logic [PARALLELISM-1:0][DATA_WIDTH-1:0] res_lane;
    logic [PARALLELISM-1:0]                 lane_ovf;
    beat_t                                  head_beat;

    // ---------------------------------------------------------------- join
    // Each side's ready is gated by the other side's valid so that neither
    // stream is consumed alone.
    assign x_ready = in_y_valid & adv;
    assign y_ready = in_x_valid & adv;
    assign fire    = in_x_valid & in_y_valid & adv;
    assign term    = x_end | y_end;

    // The first beat of a packet uses op_sub live; later beats use the latch.
    assign op_eff  = pkt_start ? op_sub : op_q;

    // ---------------------------------------------------------- lane math
    for (genvar i = 0; i < PARALLELISM; i++) begin : g_lane
        logic signed [DATA_WIDTH:0] xe;
        logic signed [DATA_WIDTH:0] ye;
        logic signed [DATA_WIDTH:0] sum;

        assign x_lane[i] = in_x_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
        assign y_lane[i] = in_y_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH];

        assign xe  = {x_lane[i][DATA_WIDTH-1], x_lane[i]};
        assign ye  = {y_lane[i][DATA_WIDTH-1], y_lane[i]};
        assign sum = (op_eff == OP_SUB) ? (xe - ye) : (xe + ye);

        // One guard bit: the result fits in DATA_WIDTH iff the top two agree.
        assign lane_ovf[i] = sum[DATA_WIDTH] ^ sum[DATA_WIDTH-1];

        // The guard bit holds the true sign, which picks the clamp direction.
        assign res_lane[i] = (lane_ovf[i] && (SATURATE != 0))
                           ? (sum[DATA_WIDTH] ? SMIN : SMAX)
                           : sum[DATA_WIDTH-1:0];
    end

    assign head_beat.data = res_lane;
    assign head_beat.last = x_end & y_end;
    assign head_beat.ovf  = lane_ovf;

    // ------------------------------------------------------------ pipeline
    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        logic  in_v;
        logic  rdy_in;
        logic  rdy_out;
        logic  vld;
        beat_t in_d;
        beat_t pay;

        if (k == 0) begin : g_head
            assign in_v = fire;
            assign in_d = head_beat;
        end else begin : g_tail
            assign in_v = g_stage[k-1].vld;
            assign in_d = g_stage[k-1].pay;
        end

        if (k == LATENCY - 1) begin : g_end
            assign rdy_out = out_ready;
        end else begin : g_mid
            assign rdy_out = g_stage[k+1].rdy_in;
        end

        vec_pipe_stage #(
            .WIDTH (BW)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_v),
            .in_ready  (rdy_in),
            .in_data   (in_d),
            .out_valid (vld),
            .out_ready (rdy_out),
            .out_data  (pay)
        );
    end

    assign adv       = g_stage[0].rdy_in;
    assign out_valid = g_stage[LATENCY-1].vld;
    assign out_data  = g_stage[LATENCY-1].pay.data;
    assign out_end   = g_stage[LATENCY-1].pay.last;
    assign ovf_lanes = g_stage[LATENCY-1].pay.ovf;

    // ------------------------------------------------- packet bookkeeping
    // Counter sticks at all-ones rather than wrapping on oversized packets.
    assign cnt_inc = (&beat_cnt) ? beat_cnt : beat_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_start <= 1'b1;
            op_q      <= OP_ADD;
            beat_cnt  <= '0;
            pkt_len   <= '0;
            pkt_done  <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            if (fire) begin
                if (pkt_start) op_q <= op_sub;
                // Either side's TLAST closes the packet, even on a mismatch.
                pkt_start <= term;
                if (term) begin
                    beat_cnt <= '0;
                    pkt_len  <= cnt_inc;
                    pkt_done <= 1'b1;
                end else begin
                    beat_cnt <= cnt_inc;
                end
            end
            // A new mismatch takes priority over a coincident clear.
            if (fire && (x_end != y_end)) err_len <= 1'b1;
            else if (err_clr)             err_len <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vec_lane_addsub.sv
// -----------------------------------------------------------------------------
// tb_vec_lane_addsub
//   Directed bench for vec_lane_addsub. A saturating and a wrapping instance
//   share all inputs; a negedge monitor records every accepted output beat
//   of both, and the main sequence compares them with hand-computed values.
// -----------------------------------------------------------------------------
module tb_vec_lane_addsub;

    localparam int P    = 4;
    localparam int DW   = 32;
    localparam int LW   = 16;
    localparam int NRND = 200;

    typedef logic [P-1:0][DW-1:0] vec_t;

    typedef struct packed {
        vec_t           d;
        logic           e;
        logic [P-1:0]   o;
        vec_t           dw;
        logic [P-1:0]   ow;
    } rec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vec_t xd   = '0;
    vec_t yd   = '0;
    logic xv   = 1'b0;
    logic yv   = 1'b0;
    logic xe   = 1'b0;
    logic ye   = 1'b0;
    logic op   = 1'b0;
    logic ordy = 1'b0;
    logic eclr = 1'b0;

    logic            xr, yr, ov, oe, el, pd;
    logic [P*DW-1:0] od;
    logic [P-1:0]    ovf;
    logic [LW-1:0]   pl;

    logic            xr_w, yr_w, ov_w, oe_w, el_w, pd_w;
    logic [P*DW-1:0] od_w;
    logic [P-1:0]    ovf_w;
    logic [LW-1:0]   pl_w;

    vec_lane_addsub #(
        .PARALLELISM (P), .DATA_WIDTH (DW), .LATENCY (2), .SATURATE (1), .LEN_WIDTH (LW)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .in_x_data (xd), .in_x_valid (xv), .x_ready (xr), .x_end (xe),
        .in_y_data (yd), .in_y_valid (yv), .y_ready (yr), .y_end (ye),
        .op_sub (op),
        .out_data (od), .out_valid (ov), .out_ready (ordy), .out_end (oe),
        .ovf_lanes (ovf), .err_len (el), .err_clr (eclr),
        .pkt_len (pl), .pkt_done (pd)
    );

    vec_lane_addsub #(
        .PARALLELISM (P), .DATA_WIDTH (DW), .LATENCY (2), .SATURATE (0), .LEN_WIDTH (LW)
    ) dut_wrap (
        .clk (clk), .rst_n (rst_n),
        .in_x_data (xd), .in_x_valid (xv), .x_ready (xr_w), .x_end (xe),
        .in_y_data (yd), .in_y_valid (yv), .y_ready (yr_w), .y_end (ye),
        .op_sub (op),
        .out_data (od_w), .out_valid (ov_w), .out_ready (ordy), .out_end (oe_w),
        .ovf_lanes (ovf_w), .err_len (el_w), .err_clr (eclr),
        .pkt_len (pl_w), .pkt_done (pd_w)
    );

    // ------------------------------------------------------------ monitor
    rec_t            obs[$];
    int              done_cnt = 0;
    int              stab_bad = 0;
    logic            held     = 1'b0;
    logic [P*DW-1:0] held_d   = '0;

    always @(negedge clk) begin
        if (held && ov && (od !== held_d)) stab_bad++;
        held   = ov && !ordy;
        held_d = od;
        if (ov && ordy) obs.push_back(rec_t'({od, oe, ovf, od_w, ovf_w}));
        if (pd) done_cnt++;
    end

    // ------------------------------------------------------------ helpers
    int n_chk  = 0;
    int n_err  = 0;
    int rd_idx = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic vec_t vec4(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] c, input logic [31:0] d);
        vec_t v;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        return v;
    endfunction

    function automatic vec_t splat(input logic [31:0] a);
        return vec4(a, a, a, a);
    endfunction

    function automatic vec_t rx(input int i);
        vec_t v;
        for (int l = 0; l < P; l++) v[l] = 32'(i * 16 + l);
        return v;
    endfunction

    function automatic vec_t ry(input int i);
        vec_t v;
        for (int l = 0; l < P; l++) v[l] = 32'(i * 3 + l * 100 + 7);
        return v;
    endfunction

    function automatic vec_t rsum(input int i);
        vec_t a, b, s;
        a = rx(i);
        b = ry(i);
        for (int l = 0; l < P; l++) s[l] = a[l] + b[l];
        return s;
    endfunction

    // Present one joined beat and hold it until both sides are accepted.
    // Called and returns at posedge+1.
    task automatic send(input vec_t x, input vec_t y, input logic xl, input logic yl, input logic o);
        int k;
        xd = x; yd = y; xe = xl; ye = yl; op = o; xv = 1'b1; yv = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (xr && yr) break;
            @(posedge clk); #1;
        end
        check("fire_timeout", k < 50, 1);
        @(posedge clk); #1;
        xv = 1'b0; yv = 1'b0; xe = 1'b0; ye = 1'b0;
    endtask

    // Compare the next recorded output beat of both instances.
    task automatic take(input string tag, input vec_t ed, input logic ee, input logic [P-1:0] eo,
                        input vec_t edw, input logic [P-1:0] eow);
        int k;
        for (k = 0; k < 40 && rd_idx >= obs.size(); k++) begin
            @(posedge clk); #1;
        end
        if (rd_idx >= obs.size()) begin
            check({tag, "_timeout"}, rd_idx < obs.size(), 1);
        end else begin
            rec_t b;
            b = obs[rd_idx];
            rd_idx++;
            check({tag, "_sat"},  {b.d, b.e, b.o}, {ed, ee, eo});
            check({tag, "_wrap"}, {b.dw, b.ow},    {edw, eow});
        end
    endtask

    // ----------------------------------------------------------- sequence
    initial begin
        int d0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", ov, 0);
        check("rst_out_end", oe, 0);
        check("rst_out_data", od, 0);
        check("rst_ovf", ovf, 0);
        check("rst_err_len", el, 0);
        check("rst_pkt_len", pl, 0);
        check("rst_pkt_done", pd, 0);
        rst_n = 1'b1;
        ordy  = 1'b1;
        @(posedge clk); #1;

        // Add, 3-beat packet, latency and length reporting
        send(vec4(1, 2, 3, 4), vec4(10, 20, 30, 40), 1'b0, 1'b0, 1'b0);
        check("lat_one_edge", ov, 0);
        send(vec4(1, 2, 3, 4), vec4(10, 20, 30, 40), 1'b0, 1'b0, 1'b0);
        check("lat_two_edges", ov, 1);
        send(vec4(1, 2, 3, 4), vec4(10, 20, 30, 40), 1'b1, 1'b1, 1'b0);
        check("add_pkt_done", pd, 1);
        check("add_pkt_len", pl, 3);
        @(posedge clk); #1;
        check("add_done_pulse", pd, 0);
        take("add_b1", vec4(11, 22, 33, 44), 1'b0, 4'b0, vec4(11, 22, 33, 44), 4'b0);
        take("add_b2", vec4(11, 22, 33, 44), 1'b0, 4'b0, vec4(11, 22, 33, 44), 4'b0);
        take("add_b3", vec4(11, 22, 33, 44), 1'b1, 4'b0, vec4(11, 22, 33, 44), 4'b0);

        // Op latched per packet: mid-packet toggle ignored, next packet adds
        send(splat(5), splat(7), 1'b0, 1'b0, 1'b1);
        send(splat(5), splat(7), 1'b1, 1'b1, 1'b0);
        send(splat(5), splat(7), 1'b1, 1'b1, 1'b0);
        take("sub_a1", splat(32'hFFFF_FFFE), 1'b0, 4'b0, splat(32'hFFFF_FFFE), 4'b0);
        take("sub_a2", splat(32'hFFFF_FFFE), 1'b1, 4'b0, splat(32'hFFFF_FFFE), 4'b0);
        take("add_b",  splat(32'd12),        1'b1, 4'b0, splat(32'd12),        4'b0);

        // Saturation vs wrap, both directions
        send(vec4(32'h7FFF_FFFF, 0, 1, 32'h8000_0000), vec4(1, 5, 2, 32'h8000_0000),
             1'b1, 1'b1, 1'b0);
        take("sat_add", vec4(32'h7FFF_FFFF, 5, 3, 32'h8000_0000), 1'b1, 4'b1001,
             vec4(32'h8000_0000, 5, 3, 0), 4'b1001);
        send(vec4(32'h8000_0000, 32'h7FFF_FFFF, 0, 32'h8000_0000),
             vec4(1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000), 1'b1, 1'b1, 1'b1);
        take("sat_sub", vec4(32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0), 1'b1, 4'b0111,
             vec4(32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 0), 4'b0111);

        // Length mismatch, clear, and set-beats-clear
        for (int b = 0; b < 3; b++) send(splat(1), splat(2), 1'b0, 1'b0, 1'b0);
        check("mm_err_pre", el, 0);
        send(splat(1), splat(2), 1'b1, 1'b0, 1'b0);
        check("mm_err_set", el, 1);
        check("mm_pkt_len", pl, 4);
        check("mm_pkt_done", pd, 1);
        for (int b = 0; b < 4; b++) take("mm_beat", splat(3), 1'b0, 4'b0, splat(3), 4'b0);
        eclr = 1'b1;
        @(posedge clk); #1;
        eclr = 1'b0;
        check("mm_clear", el, 0);
        eclr = 1'b1;
        send(splat(1), splat(2), 1'b0, 1'b1, 1'b0);
        eclr = 1'b0;
        check("mm_set_wins", el, 1);
        check("mm_pkt_len2", pl, 1);
        take("mm_beat5", splat(3), 1'b0, 4'b0, splat(3), 4'b0);
        eclr = 1'b1;
        @(posedge clk); #1;
        eclr = 1'b0;
        check("mm_clear2", el, 0);

        // Random backpressure and input skew against the model
        d0 = done_cnt;
        fork
            begin : prod
                int i;
                logic f;
                i = 0;
                for (int c = 0; c < 8000 && i < NRND; c++) begin
                    xd = rx(i); yd = ry(i); op = 1'b0;
                    xe = (i % 8 == 7); ye = (i % 8 == 7);
                    if (!xv && ($urandom_range(0, 1) == 1)) xv = 1'b1;
                    if (!yv && ($urandom_range(0, 1) == 1)) yv = 1'b1;
                    @(negedge clk);
                    f = xv && yv && xr && yr;
                    @(posedge clk); #1;
                    if (f) begin
                        i++;
                        xv = 1'b0; yv = 1'b0;
                    end
                end
                xv = 1'b0; yv = 1'b0; xe = 1'b0; ye = 1'b0;
            end
            begin : cons
                for (int c = 0; c < 9000 && (obs.size() - rd_idx) < NRND; c++) begin
                    ordy = ($urandom_range(0, 1) == 1);
                    @(posedge clk); #1;
                end
                ordy = 1'b1;
            end
        join
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("rnd_count", obs.size() - rd_idx, NRND);
        for (int i = 0; i < NRND; i++)
            take("rnd_beat", rsum(i), (i % 8 == 7), 4'b0, rsum(i), 4'b0);
        check("rnd_pkts", done_cnt - d0, NRND / 8);
        check("rnd_pkt_len", pl, 8);
        check("rnd_stable", stab_bad, 0);

        // Reset with two beats stalled in the pipeline
        ordy = 1'b0;
        send(splat(5), splat(7), 1'b0, 1'b0, 1'b1);
        send(splat(5), splat(7), 1'b0, 1'b0, 1'b1);
        check("rstm_full", ov, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstm_async_valid", ov, 0);
        check("rstm_pkt_len", pl, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ordy  = 1'b1;
        @(posedge clk); #1;
        send(splat(5), splat(7), 1'b1, 1'b1, 1'b0);
        check("rstm_len_one", pl, 1);
        take("rstm_beat", splat(32'd12), 1'b1, 4'b0, splat(32'd12), 4'b0);

        check("wrap_lockstep", {xr_w, yr_w, ov_w, oe_w, el_w, pl_w, pd_w},
              {xr, yr, ov, oe, el, pl, pd});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
